mem_lsu: RTL and testbench

Load/store initiator that drives the single-port physical-memory model's `valid/raddr/rdata/wen/waddr/wdata/wmask` interface on behalf of the core's execute stage. It accepts one load or store at a time over a valid/ready request channel and aligns store data and byte masks to 32-bit words. It extracts and sign- or zero-extends load data, flags misaligned accesses, and returns a response over a valid/ready channel. A configurable wait counter models memory latency, so pipeline stalls are exercised before a real bus exists.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_lsu_align.sv | 40 ++++
 rtl/mem_lsu.sv | 147 ++++++++++++++
 tb/tb_mem_lsu.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the load/store unit.
// Size codes, FSM states and lane-mask helper.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_e;

  function automatic logic [3:0] base_mask(input logic [1:0] size);
    logic [3:0] m;
    m = 4'b0000;
    unique case (size)
      SZ_B:    m = 4'b0001;
      SZ_H:    m = 4'b0011;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering for stores and load extraction.
// Purely combinational; also flags misaligned accesses.
module mem_lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_sh,
  output logic [7:0]  wmask,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [31:0] rsh;
  logic [3:0]  lane;

  // Alignment check, store lanes and load extension
  always_comb begin
    misaligned = 1'b0;
    unique case (1'b1)
      (size == SZ_H): misaligned = off[0];
      (size == SZ_W): misaligned = (off != 2'd0);
      (size == 2'd3): misaligned = 1'b1;
      default:        misaligned = 1'b0;
    endcase
    wdata_sh = wdata << {off, 3'b000};
    lane     = base_mask(size) << off;
    wmask    = {4'b0000, lane};
    rsh      = rdata >> {off, 3'b000};
    unique case (size)
      SZ_B:    rdata_ext = {{24{~uns & rsh[7]}}, rsh[7:0]};
      SZ_H:    rdata_ext = {{16{~uns & rsh[15]}}, rsh[15:0]};
      default: rdata_ext = rsh;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator for the physical-memory model.
// One transaction at a time with modelled access latency.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_wen,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask
);

  localparam logic [3:0] CNT_INIT =
    (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e      state, state_nx;
  logic [3:0]  cnt;
  logic        wen_q, uns_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic [1:0]  a_size, a_off;
  logic [31:0] a_wdata, a_rdata;
  logic [7:0]  a_wmask;
  logic        a_mis;
  logic        accept;
  logic [31:0] word_addr;

  // In IDLE the check looks at the live request, else at the latch
  assign a_size    = (state == IDLE) ? req_size : size_q;
  assign a_off     = (state == IDLE) ? req_addr[1:0] : addr_q[1:0];
  assign accept    = req_valid & req_ready;
  assign word_addr = {addr_q[31:2], 2'b00};

  mem_lsu_align u_align (
    .size       (a_size),
    .off        (a_off),
    .uns        (uns_q),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .wdata_sh   (a_wdata),
    .wmask      (a_wmask),
    .rdata_ext  (a_rdata),
    .misaligned (a_mis)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and memory/handshake outputs
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_valid  = 1'b0;
    mem_wen    = 1'b0;
    mem_raddr  = 32'd0;
    mem_waddr  = 32'd0;
    mem_wdata  = 32'd0;
    mem_wmask  = 8'd0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (a_mis)            state_nx = RESP;
          else if (LATENCY > 0) state_nx = WAIT;
          else                  state_nx = ACCESS;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nx = ACCESS;
      end
      ACCESS: begin
        mem_valid = 1'b1;
        mem_wen   = wen_q;
        mem_raddr = word_addr;
        mem_waddr = word_addr;
        mem_wdata = a_wdata;
        mem_wmask = a_wmask;
        state_nx  = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign resp_rdata = resp_valid ? rdata_q : 32'd0;
  assign resp_err   = resp_valid & err_q;

  // Latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (accept && !a_mis && LATENCY > 0) begin
      cnt <= CNT_INIT;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Request latch and response data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'd0;
      rdata_q <= 32'd0;
    end else begin
      if (accept) begin
        wen_q   <= req_wen;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
        err_q   <= a_mis;
        rdata_q <= 32'd0;
      end
      if (state == ACCESS && !wen_q) rdata_q <= a_rdata;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu at three latencies.
// Random and directed loads/stores against a byte-array model.
module tb_mem_lsu;
  import mem_pkg::*;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_n        [N];
  logic        req_valid    [N];
  logic        req_ready    [N];
  logic        req_wen      [N];
  logic [31:0] req_addr     [N];
  logic [31:0] req_wdata    [N];
  logic [1:0]  req_size     [N];
  logic        req_unsigned [N];
  logic        resp_valid   [N];
  logic        resp_ready   [N];
  logic [31:0] resp_rdata   [N];
  logic        resp_err     [N];
  logic        mem_valid    [N];
  logic [31:0] mem_raddr    [N];
  logic [31:0] mem_rdata    [N];
  logic        mem_wen      [N];
  logic [31:0] mem_waddr    [N];
  logic [31:0] mem_wdata    [N];
  logic [7:0]  mem_wmask    [N];

  bit [31:0]   mem     [N][256];
  bit [7:0]    ref_b   [N][1024];
  int          strobes [N];
  int          idle_bad[N];
  logic [31:0] last_waddr [N];
  logic [31:0] last_wdata [N];
  logic [7:0]  last_wmask [N];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 1) ? 0 : (k == 2) ? 3 : 1;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_lsu #(.LATENCY(g == 1 ? 0 : (g == 2 ? 3 : 1))) u_dut (
      .clk          (clk),
      .rst_n        (rst_n[g]),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_wen      (req_wen[g]),
      .req_addr     (req_addr[g]),
      .req_wdata    (req_wdata[g]),
      .req_size     (req_size[g]),
      .req_unsigned (req_unsigned[g]),
      .resp_valid   (resp_valid[g]),
      .resp_ready   (resp_ready[g]),
      .resp_rdata   (resp_rdata[g]),
      .resp_err     (resp_err[g]),
      .mem_valid    (mem_valid[g]),
      .mem_raddr    (mem_raddr[g]),
      .mem_rdata    (mem_rdata[g]),
      .mem_wen      (mem_wen[g]),
      .mem_waddr    (mem_waddr[g]),
      .mem_wdata    (mem_wdata[g]),
      .mem_wmask    (mem_wmask[g])
    );
    assign mem_rdata[g] = mem[g][mem_raddr[g][9:2]];
  end

  // Memory model: apply strobed writes, count strobes
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (mem_valid[k] === 1'b1) begin
        strobes[k] = strobes[k] + 1;
        if (mem_wen[k] === 1'b1) begin
          last_waddr[k] = mem_waddr[k];
          last_wdata[k] = mem_wdata[k];
          last_wmask[k] = mem_wmask[k];
          for (int b = 0; b < 4; b++)
            if (mem_wmask[k][b])
              mem[k][mem_waddr[k][9:2]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
        end
      end
    end
  end

  // Memory outputs must be quiet when no strobe is issued
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (mem_valid[k] !== 1'b1 &&
          (mem_wen[k] !== 1'b0 || mem_raddr[k] !== 32'd0 ||
           mem_waddr[k] !== 32'd0 || mem_wdata[k] !== 32'd0 ||
           mem_wmask[k] !== 8'd0))
        idle_bad[k] = idle_bad[k] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction: drive, wait, compare with the byte model
  task automatic run(input int k, input bit wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size,
                     input bit uns, input int hold,
                     output logic [31:0] rd);
    bit          mis;
    int          nb, a, cyc, s0, exp_lat;
    longint      v;
    logic [31:0] exp_rd, r0;
    logic        e0;
    mis = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
          (size == 2'd2 && addr[1:0] != 2'd0);
    nb  = 1 << size;
    a   = int'(addr[9:0]);
    exp_rd = 32'd0;
    if (!mis && wen) begin
      for (int i = 0; i < nb; i++) ref_b[k][a + i] = wdata[8*i +: 8];
    end else if (!mis) begin
      v = 0;
      for (int i = 0; i < nb; i++) v = v | (longint'(ref_b[k][a + i]) << (8 * i));
      if (!uns && v[8*nb-1]) v = v - (longint'(1) << (8 * nb));
      exp_rd = v[31:0];
    end
    exp_lat = mis ? 1 : lat_of(k) + 2;
    s0 = strobes[k];
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1; req_wen[k] = wen; req_addr[k] = addr;
    req_wdata[k] = wdata; req_size[k] = size; req_unsigned[k] = uns;
    @(posedge clk); #1;
    req_valid[k] = 1'b0; req_wen[k] = 1'($urandom);
    req_addr[k] = $urandom; req_wdata[k] = $urandom;
    req_size[k] = 2'($urandom); req_unsigned[k] = 1'($urandom);
    cyc = 1;
    while (resp_valid[k] !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("resp_rdata", resp_rdata[k], exp_rd);
    chk("resp_err", 32'(resp_err[k]), 32'(mis));
    chk("strobes", 32'(strobes[k] - s0), mis ? 32'd0 : 32'd1);
    rd = resp_rdata[k];
    r0 = resp_rdata[k]; e0 = resp_err[k];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(resp_valid[k]), 32'd1);
      chk("hold_rdata", resp_rdata[k], r0);
      chk("hold_err", 32'(resp_err[k]), 32'(e0));
      chk("hold_req_ready", 32'(req_ready[k]), 32'd0);
      chk("hold_strobes", 32'(strobes[k] - s0), mis ? 32'd0 : 32'd1);
    end
    resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    resp_ready[k] = 1'b0;
    chk("resp_done", 32'(resp_valid[k]), 32'd0);
    chk("ready_again", 32'(req_ready[k]), 32'd1);
  endtask

  task automatic chk_reset_outs(input int k);
    chk("rst_req_ready", 32'(req_ready[k]), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
    chk("rst_resp_rdata", resp_rdata[k], 32'd0);
    chk("rst_resp_err", 32'(resp_err[k]), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid[k]), 32'd0);
    chk("rst_mem_wen", 32'(mem_wen[k]), 32'd0);
    chk("rst_mem_waddr", mem_waddr[k], 32'd0);
    chk("rst_mem_wmask", 32'(mem_wmask[k]), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int s0, seen;
    for (int k = 0; k < N; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_wen[k] = 1'b0;
      req_addr[k] = 32'd0; req_wdata[k] = 32'd0; req_size[k] = 2'd0;
      req_unsigned[k] = 1'b0; resp_ready[k] = 1'b0;
      strobes[k] = 0; idle_bad[k] = 0;
      last_waddr[k] = 32'd0; last_wdata[k] = 32'd0; last_wmask[k] = 8'd0;
    end
    #1;
    for (int k = 0; k < N; k++) chk_reset_outs(k);
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) rst_n[k] = 1'b1;

    // Word store then load at every latency
    for (int k = 0; k < N; k++) begin
      run(k, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, SZ_W, 1'b0, 0, rd);
      chk("st_waddr", last_waddr[k], 32'h8000_0004);
      chk("st_wmask", 32'(last_wmask[k]), 32'h0F);
      chk("st_wdata", last_wdata[k], 32'hDEAD_BEEF);
      run(k, 1'b0, 32'h8000_0004, 32'd0, SZ_W, 1'b0, 0, rd);
      chk("ld_word", rd, 32'hDEAD_BEEF);
    end

    // Byte store then signed and unsigned loads
    run(0, 1'b1, 32'h8000_0003, 32'h0000_0080, SZ_B, 1'b0, 0, rd);
    chk("stb_wdata", last_wdata[0], 32'h8000_0000);
    chk("stb_wmask", 32'(last_wmask[0]), 32'h08);
    run(0, 1'b0, 32'h8000_0003, 32'd0, SZ_B, 1'b0, 0, rd);
    chk("ldb_signed", rd, 32'hFFFF_FF80);
    run(0, 1'b0, 32'h8000_0003, 32'd0, SZ_B, 1'b1, 0, rd);
    chk("ldb_unsigned", rd, 32'h0000_0080);

    // Misaligned half and backpressure
    run(0, 1'b0, 32'h8000_0001, 32'd0, SZ_H, 1'b0, 0, rd);
    run(0, 1'b0, 32'h8000_0004, 32'd0, SZ_W, 1'b0, 5, rd);
    run(2, 1'b1, 32'h8000_0006, 32'h1234_ABCD, 2'd3, 1'b0, 2, rd);

    // Reset while waiting on the latency counter
    s0 = strobes[2];
    @(negedge clk);
    req_valid[2] = 1'b1; req_wen[2] = 1'b1; req_addr[2] = 32'h8000_0010;
    req_wdata[2] = 32'hCAFE_F00D; req_size[2] = SZ_W;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    rst_n[2] = 1'b0;
    #1;
    chk_reset_outs(2);
    @(negedge clk);
    rst_n[2] = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (resp_valid[2] === 1'b1) seen++;
    end
    chk("rst_no_resp", 32'(seen), 32'd0);
    chk("rst_no_strobe", 32'(strobes[2] - s0), 32'd0);
    chk("rst_ready_after", 32'(req_ready[2]), 32'd1);
    run(2, 1'b0, 32'h8000_0010, 32'd0, SZ_W, 1'b0, 0, rd);

    // Randomized traffic
    for (int k = 0; k < N; k++) begin
      for (int t = 0; t < 60; t++) begin
        logic [31:0] addr;
        addr = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2) |
               32'($urandom_range(0, 3));
        run(k, 1'($urandom), addr, $urandom, 2'($urandom_range(0, 3)),
            1'($urandom), $urandom_range(0, 2), rd);
      end
      chk("idle_outputs_zero", 32'(idle_bad[k]), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
